// File: rtl/timer_tx.sv
// ---------------------------------------------------------------------------
// timer_tx
//   UART transmit-side pacing timer. Sits between the TX holding register /
//   FIFO and the UART transmitter. It grants each frame start with a
//   one-cycle pulse. After each frame it enforces a programmable idle gap,
//   counted in bit times. It flags an idle timeout when no new byte arrives
//   within IDLE_BITS bit times after the gap.
//
// Handshake: tx_req is a level ("a byte is ready"). tx_start is the grant,
//   a registered one-cycle pulse. Once tx_start has fired, the block waits
//   for the transmitter's tx_done pulse before it grants again. tx_done
//   seen outside a frame is ignored.
//
// Ports
//   clk_i       in   1   clock
//   rst_ni      in   1   asynchronous, active-low reset
//   baud        in   16  clocks per bit; 0 treated as 1
//   gap_bits    in   4   inter-frame idle gap in bit times (0 = no gap)
//   tx_en       in   1   pacing enable
//   tx_req      in   1   level: a byte is ready to send
//   tx_done     in   1   pulse from transmitter: stop bit complete
//   tx_start    out  1   registered one-cycle pulse: transmitter may start
//   gap_active  out  1   high while in GAP
//   tx_timeout  out  1   registered one-cycle pulse: TX idle timeout
//   dbg_state   out  2   current FSM state (0 IDLE, 1 BUSY, 2 GAP, 3 WAIT)
// ---------------------------------------------------------------------------
module timer_tx #(
    parameter int unsigned IDLE_BITS = 10
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] baud,
    input  logic [3:0]  gap_bits,
    input  logic        tx_en,
    input  logic        tx_req,
    input  logic        tx_done,
    output logic        tx_start,
    output logic        gap_active,
    output logic        tx_timeout,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    localparam logic [7:0] IDLE_BITS_W = 8'(IDLE_BITS);

    state_t      state_q, state_d;
    logic [15:0] b_clk_count_q;
    logic [7:0]  bit_count_q;
    logic        tx_start_q, tx_timeout_q;
    logic        start_d, timeout_d;

    logic [15:0] baud_m1;
    logic        tick;
    logic [7:0]  bit_count_inc;
    logic        counting;

    // baud=0 behaves like baud=1, so the tick fires every clock.
    assign baud_m1       = (baud == 16'd0) ? 16'd0 : baud - 16'd1;
    assign tick          = (b_clk_count_q == baud_m1);
    // The bit count this tick would produce. Comparing against it lets
    // the state change on the same edge as the final tick.
    assign bit_count_inc = bit_count_q + 8'd1;
    assign counting      = (state_q == S_GAP) || (state_q == S_WAIT);

    // State register, bit-time counters and registered pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            b_clk_count_q <= 16'd0;
            bit_count_q   <= 8'd0;
            tx_start_q    <= 1'b0;
            tx_timeout_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_start_q   <= start_d;
            tx_timeout_q <= timeout_d;
            if ((state_d != state_q) || !counting) begin
                b_clk_count_q <= 16'd0;
                bit_count_q   <= 8'd0;
            end else if (tick) begin
                b_clk_count_q <= 16'd0;
                bit_count_q   <= bit_count_inc;
            end else begin
                b_clk_count_q <= b_clk_count_q + 16'd1;
            end
        end
    end

    // Next-state logic and pulse requests.
    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_en && tx_req) begin
                    state_d = S_BUSY;
                    start_d = 1'b1;
                end
            end
            S_BUSY: begin
                // A frame in flight always completes. Disabling only
                // decides where the FSM lands afterwards.
                if (tx_done) begin
                    if (!tx_en)                 state_d = S_IDLE;
                    else if (gap_bits != 4'd0)  state_d = S_GAP;
                    else                        state_d = S_WAIT;
                end
            end
            S_GAP: begin
                if (!tx_en)
                    state_d = S_IDLE;
                else if (tick && (bit_count_inc == {4'd0, gap_bits}))
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                // The request is checked first, so it wins over a
                // coincident final tick.
                if (!tx_en) begin
                    state_d = S_IDLE;
                end else if (tx_req) begin
                    state_d = S_BUSY;
                    start_d = 1'b1;
                end else if (tick && (bit_count_inc == IDLE_BITS_W)) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        tx_start   = tx_start_q;
        tx_timeout = tx_timeout_q;
        gap_active = (state_q == S_GAP);
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_timer_tx.sv
module tb_timer_tx;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd3;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] baud = 16'd4;
  logic [3:0]  gap_bits = 4'd0;
  logic        tx_en = 1'b0;
  logic        tx_req = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_start, gap_active, tx_timeout;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  timer_tx #(.IDLE_BITS(10)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .baud(baud), .gap_bits(gap_bits),
    .tx_en(tx_en), .tx_req(tx_req), .tx_done(tx_done),
    .tx_start(tx_start), .gap_active(gap_active), .tx_timeout(tx_timeout),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_dut(input logic [15:0] b, input logic [3:0] g);
    tx_en = 1'b0; tx_req = 1'b0; tx_done = 1'b0;
    baud = b; gap_bits = g;
    rst_ni = 1'b0;
    step(); step();
    rst_ni = 1'b1;
    step();
    tx_en = 1'b1;
  endtask

  task automatic start_frame(input string tag);
    tx_req = 1'b1;
    step();
    check(tag, tx_start, 1);
  endtask

  // The sample taken right after the tx_done edge counts as latency 0.
  task automatic pulse_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic wait_start(output int lat, output int gapc);
    lat = 0; gapc = 0;
    while (tx_start !== 1'b1 && lat < 300) begin
      if (gap_active) gapc++;
      step();
      lat++;
    end
  endtask

  task automatic wait_timeout(output int lat, output int starts);
    lat = 0; starts = 0;
    while (tx_timeout !== 1'b1 && lat < 300) begin
      if (tx_start) starts++;
      step();
      lat++;
    end
  endtask

  initial begin
    int lat, gapc, n;

    // Reset state
    reset_dut(16'd4, 4'd2);
    check("rst_start", tx_start, 0);
    check("rst_gap", gap_active, 0);
    check("rst_timeout", tx_timeout, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // 1: baud=4 gap=2: gap 8 clocks, start at +9, one cycle wide
    start_frame("t1_first_start");
    step();
    check("t1_start_width", tx_start, 0);
    check("t1_busy", dbg_state, ST_BUSY);
    pulse_done();
    wait_start(lat, gapc);
    check("t1_latency", lat, 9);
    check("t1_gap_cycles", gapc, 8);
    step();
    check("t1_start_width2", tx_start, 0);

    // 2: gap=0, no request: timeout at +40, then idle and quiet
    reset_dut(16'd4, 4'd0);
    start_frame("t2_start");
    tx_req = 1'b0;
    step();
    pulse_done();
    check("t2_wait", dbg_state, ST_WAIT);
    wait_timeout(lat, n);
    check("t2_timeout_lat", lat, 40);
    check("t2_no_start", n, 0);
    check("t2_idle", dbg_state, ST_IDLE);
    step();
    check("t2_timeout_width", tx_timeout, 0);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx_timeout) n++;
      step();
    end
    check("t2_no_more_timeouts", n, 0);

    // 3: request sampled on the 40th edge wins over the timeout
    reset_dut(16'd4, 4'd0);
    start_frame("t3_start");
    tx_req = 1'b0;
    pulse_done();
    repeat (39) step();
    check("t3_no_early_timeout", tx_timeout, 0);
    tx_req = 1'b1;
    step();
    check("t3_req_wins_start", tx_start, 1);
    check("t3_req_wins_timeout", tx_timeout, 0);
    check("t3_busy", dbg_state, ST_BUSY);
    step();
    check("t3_timeout_after", tx_timeout, 0);

    // 4: async reset in the middle of a gap
    reset_dut(16'd8, 4'd3);
    start_frame("t4_start");
    pulse_done();
    repeat (3) step();
    check("t4_in_gap", gap_active, 1);
    tx_req = 1'b0;
    rst_ni = 1'b0;
    #2;
    check("t4_async_gap", gap_active, 0);
    check("t4_async_start", tx_start, 0);
    check("t4_async_timeout", tx_timeout, 0);
    check("t4_async_state", dbg_state, ST_IDLE);
    step();
    rst_ni = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (tx_start) n++;
    end
    check("t4_no_start_wo_req", n, 0);
    tx_req = 1'b1;
    step();
    check("t4_start_after_req", tx_start, 1);

    // 5a: tx_en dropped in WAIT -> IDLE, no timeout
    reset_dut(16'd4, 4'd0);
    start_frame("t5a_start");
    tx_req = 1'b0;
    pulse_done();
    repeat (10) step();
    tx_en = 1'b0;
    step();
    check("t5a_idle", dbg_state, ST_IDLE);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx_timeout) n++;
      step();
    end
    check("t5a_no_timeout", n, 0);

    // 5b: baud=0, gap=1: gap 1 clock, start at +2
    reset_dut(16'd0, 4'd1);
    start_frame("t5b_start");
    pulse_done();
    wait_start(lat, gapc);
    check("t5b_latency", lat, 2);
    check("t5b_gap_cycles", gapc, 1);

    // tx_en dropped in BUSY: frame ends, then IDLE rather than GAP
    reset_dut(16'd4, 4'd2);
    start_frame("ten_start");
    tx_en = 1'b0;
    repeat (3) step();
    check("ten_still_busy", dbg_state, ST_BUSY);
    pulse_done();
    check("ten_idle", dbg_state, ST_IDLE);
    check("ten_no_gap", gap_active, 0);

    // 6: request held through BUSY, stray tx_done during GAP
    reset_dut(16'd2, 4'd3);
    start_frame("t6_start");
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tx_start) n++;
    end
    check("t6_no_regrant_busy", n, 0);
    pulse_done();
    n = 0; lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 2 || i == 4) tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      if (tx_start) begin
        n++;
        if (lat < 0) lat = i;
      end
    end
    check("t6_one_start", n, 1);
    check("t6_latency", lat, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
